// File: rtl/uart_txq_pkg.sv
// Shared types and constants for the UART transmit queue: FSM encoding,
// ASCII control codes and the serializer setup word used by SOC and bench.
package uart_txq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        GUARD = 2'd2,
        WAIT  = 2'd3
    } txState_t;

    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

    // 115200 baud 8N1: upper byte selects 8 data bits, no parity, one stop bit
    localparam logic [23:0] UART_BAUD_DIV = 24'h000364;
    localparam logic [31:0] UART_SETUP    = {8'h00, UART_BAUD_DIV};

    function automatic int unsigned levelWidth(input int unsigned depth);
        return unsigned'($clog2(depth)) + 1;
    endfunction

endpackage

// File: rtl/uart_tx_queue_if.sv
// Bus between the SOC IO write path / txuart serializer and uart_tx_queue.
// master = SOC side, slave = the queue.
interface uart_tx_queue_if
    import uart_txq_pkg::*;
#(
    parameter int unsigned DEPTH = 16
);
    localparam int unsigned LW = levelWidth(DEPTH);

    logic          wr_i;
    logic [7:0]    wdata_i;
    logic          full_o;
    logic          empty_o;
    logic [LW-1:0] level_o;
    logic          ovf_o;
    logic          ovfClr_i;
    logic          uartWr_o;
    logic [7:0]    uartData_o;
    logic          uartBusy_i;

    modport master (
        output wr_i, wdata_i, ovfClr_i, uartBusy_i,
        input  full_o, empty_o, level_o, ovf_o, uartWr_o, uartData_o
    );

    modport slave (
        input  wr_i, wdata_i, ovfClr_i, uartBusy_i,
        output full_o, empty_o, level_o, ovf_o, uartWr_o, uartData_o
    );

endinterface

// File: rtl/uart_tx_queue_fifo.sv
// sync_fifo: circular buffer with read/write pointers and an entry count.
// Caller guarantees push only when not full (or popping) and pop only when not empty.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       wdata,
    output logic [WIDTH-1:0]       head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rdPtr;
    logic [AW-1:0]    wrPtr;
    logic [AW:0]      count;

    // DEPTH is a power of two, so pointers wrap by natural overflow
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
        end else begin
            if (push) wrPtr <= wrPtr + 1'b1;
            if (pop)  rdPtr <= rdPtr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wrPtr] <= wdata;
    end

    assign head  = mem[rdPtr];
    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);
    assign level = count;

endmodule

// File: rtl/uart_tx_queue.sv
// Transmit queue and sequencer feeding txuart one byte per idle period.
// Optional CR insertion before LF when UART_TXQ_CRLF_EN is defined.
module uart_tx_queue
    import uart_txq_pkg::*;
#(
    parameter int unsigned DEPTH = 16
) (
    input  logic            clk_i,
    input  logic            reset_i,
    uart_tx_queue_if.slave  bus
);
    txState_t               state;
    txState_t               stateNext;
    logic                   uartWrQ;
    logic                   uartWrNext;
    logic [7:0]             uartDataQ;
    logic [7:0]             uartDataNext;
    logic                   ovfQ;
    logic                   push;
    logic                   pop;
    logic                   ovfSet;
    logic [7:0]             head;
    logic                   fifoFull;
    logic                   fifoEmpty;
    logic [$clog2(DEPTH):0] fifoLevel;
    logic                   emitCr;

`ifdef UART_TXQ_CRLF_EN
    logic crPending;
    logic crPendingNext;
    assign emitCr = (head == ASCII_LF) && !crPending;
`else
    assign emitCr = 1'b0;
`endif

    assign push   = bus.wr_i && (!fifoFull || pop);
    assign ovfSet = bus.wr_i && fifoFull && !pop;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk_i),
        .rst   (reset_i),
        .push  (push),
        .pop   (pop),
        .wdata (bus.wdata_i),
        .head  (head),
        .full  (fifoFull),
        .empty (fifoEmpty),
        .level (fifoLevel)
    );

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state     <= IDLE;
            uartWrQ   <= 1'b0;
            uartDataQ <= '0;
            ovfQ      <= 1'b0;
`ifdef UART_TXQ_CRLF_EN
            crPending <= 1'b0;
`endif
        end else begin
            state     <= stateNext;
            uartWrQ   <= uartWrNext;
            uartDataQ <= uartDataNext;
            if (ovfSet)            ovfQ <= 1'b1;
            else if (bus.ovfClr_i) ovfQ <= 1'b0;
`ifdef UART_TXQ_CRLF_EN
            crPending <= crPendingNext;
`endif
        end
    end

    // Strobe and data are computed on entry to SEND and registered,
    // so they are asserted exactly during the SEND cycle.
    always_comb begin
        stateNext    = state;
        uartWrNext   = 1'b0;
        uartDataNext = uartDataQ;
        pop          = 1'b0;
`ifdef UART_TXQ_CRLF_EN
        crPendingNext = crPending;
`endif
        case (state)
            IDLE: begin
                if (!fifoEmpty && !bus.uartBusy_i) begin
                    stateNext    = SEND;
                    uartWrNext   = 1'b1;
                    uartDataNext = emitCr ? ASCII_CR : head;
                end
            end
            SEND: begin
                pop       = !emitCr;
                stateNext = GUARD;
`ifdef UART_TXQ_CRLF_EN
                crPendingNext = emitCr;
`endif
            end
            GUARD: stateNext = WAIT;
            WAIT: begin
                if (!bus.uartBusy_i) stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    assign bus.uartWr_o   = uartWrQ;
    assign bus.uartData_o = uartDataQ;
    assign bus.ovf_o      = ovfQ;
    assign bus.full_o     = fifoFull;
    assign bus.empty_o    = fifoEmpty;
    assign bus.level_o    = fifoLevel;

endmodule

// File: tb/tb_uart_tx_queue.sv
// Directed self-checking bench for uart_tx_queue with a simple txuart busy model.
// Honours UART_TXQ_CRLF_EN for the CR insertion expectation.
module tb_uart_tx_queue;
    import uart_txq_pkg::*;

    localparam int unsigned DEPTH = 8;

    typedef struct {
        int unsigned cyc;
        logic [7:0]  data;
    } strobe_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        holdBusy = 1'b0;
    int unsigned busyCnt = 0;
    int unsigned cyc = 0;
    int          nAsserts = 0;
    int          nFails = 0;
    logic        prevWr = 1'b0;
    strobe_t     logQ[$];
    logic [7:0]  crExp[$];
    int unsigned n0;
    logic        found;

    always #5 clk = ~clk;

    uart_tx_queue_if #(.DEPTH(DEPTH)) bus();

    uart_tx_queue #(.DEPTH(DEPTH)) dut (
        .clk_i   (clk),
        .reset_i (rst),
        .bus     (bus)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // txuart model: busy for 20 cycles starting the cycle after the write strobe
    always @(posedge clk) begin
        if (bus.uartWr_o)     busyCnt <= 20;
        else if (busyCnt > 0) busyCnt <= busyCnt - 1;
    end
    assign bus.uartBusy_i = holdBusy || (busyCnt != 0);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nAsserts++;
        assert (obs === exp) else begin
            nFails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (bus.uartWr_o) begin
            check("strobeWidth", {31'd0, prevWr}, 32'd0);
            logQ.push_back('{cyc, bus.uartData_o});
        end
        prevWr = bus.uartWr_o;
    end

    task automatic pushByte(input logic [7:0] b);
        bus.wr_i    = 1'b1;
        bus.wdata_i = b;
        @(negedge clk);
        bus.wr_i    = 1'b0;
    endtask

    initial begin
        bus.wr_i     = 1'b0;
        bus.wdata_i  = 8'h00;
        bus.ovfClr_i = 1'b0;

        repeat (3) @(negedge clk);
        check("rstWr",    {31'd0, bus.uartWr_o}, 32'd0);
        check("rstData",  {24'd0, bus.uartData_o}, 32'd0);
        check("rstOvf",   {31'd0, bus.ovf_o}, 32'd0);
        check("rstEmpty", {31'd0, bus.empty_o}, 32'd1);
        check("rstFull",  {31'd0, bus.full_o}, 32'd0);
        check("rstLevel", 32'(bus.level_o), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // single byte: strobe in cycle N+2
        n0 = cyc;
        pushByte(8'h41);
        check("n1Empty", {31'd0, bus.empty_o}, 32'd0);
        check("n1Level", 32'(bus.level_o), 32'd1);
        @(negedge clk);
        check("n2Wr",   {31'd0, bus.uartWr_o}, 32'd1);
        check("n2Data", {24'd0, bus.uartData_o}, 32'h41);
        @(negedge clk);
        check("n3Empty", {31'd0, bus.empty_o}, 32'd1);
        check("n3Level", 32'(bus.level_o), 32'd0);
        check("n3Wr",    {31'd0, bus.uartWr_o}, 32'd0);
        repeat (30) @(negedge clk);
        check("singleCount", logQ.size(), 32'd1);
        check("singleCyc",   logQ[0].cyc, n0 + 2);

        // back-to-back sequencing: 20 busy + GUARD + IDLE->SEND gives 23-cycle spacing
        logQ.delete();
        pushByte(8'h48);
        pushByte(8'h69);
        pushByte(8'h21);
        repeat (80) @(negedge clk);
        check("seqCount", logQ.size(), 32'd3);
        check("seqD0", {24'd0, logQ[0].data}, 32'h48);
        check("seqD1", {24'd0, logQ[1].data}, 32'h69);
        check("seqD2", {24'd0, logQ[2].data}, 32'h21);
        check("seqGap1", logQ[1].cyc - logQ[0].cyc, 32'd23);
        check("seqGap2", logQ[2].cyc - logQ[1].cyc, 32'd23);

        // overflow
        logQ.delete();
        holdBusy = 1'b1;
        for (int i = 0; i < DEPTH + 2; i++) pushByte(8'h10 + 8'(i));
        check("ovfFull",  {31'd0, bus.full_o}, 32'd1);
        check("ovfLevel", 32'(bus.level_o), DEPTH);
        check("ovfFlag",  {31'd0, bus.ovf_o}, 32'd1);
        holdBusy = 1'b0;
        repeat (DEPTH * 23 + 30) @(negedge clk);
        check("ovfSent", logQ.size(), DEPTH);
        for (int i = 0; i < DEPTH; i++) check("ovfData", {24'd0, logQ[i].data}, 32'h10 + i);
        check("ovfSticky", {31'd0, bus.ovf_o}, 32'd1);
        check("ovfDrained", {31'd0, bus.empty_o}, 32'd1);
        bus.ovfClr_i = 1'b1;
        @(negedge clk);
        bus.ovfClr_i = 1'b0;
        check("ovfClr", {31'd0, bus.ovf_o}, 32'd0);

        // push while full during SEND is accepted
        logQ.delete();
        holdBusy = 1'b1;
        for (int i = 0; i < DEPTH; i++) pushByte(8'h20 + 8'(i));
        check("ppFull", {31'd0, bus.full_o}, 32'd1);
        holdBusy = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 5 && !found; i++) begin
            @(negedge clk);
            if (bus.uartWr_o) found = 1'b1;
        end
        check("ppSendSeen", {31'd0, found}, 32'd1);
        pushByte(8'h20 + 8'(DEPTH));
        check("ppLevel", 32'(bus.level_o), DEPTH);
        check("ppOvf",   {31'd0, bus.ovf_o}, 32'd0);
        check("ppFull2", {31'd0, bus.full_o}, 32'd1);
        repeat ((DEPTH + 1) * 23 + 30) @(negedge clk);
        check("ppSent", logQ.size(), DEPTH + 1);
        for (int i = 0; i <= DEPTH; i++) check("ppData", {24'd0, logQ[i].data}, 32'h20 + i);

        // LF handling
        logQ.delete();
`ifdef UART_TXQ_CRLF_EN
        crExp = '{8'h61, ASCII_CR, ASCII_LF};
`else
        crExp = '{8'h61, ASCII_LF};
`endif
        pushByte(8'h61);
        pushByte(8'h0A);
        repeat (100) @(negedge clk);
        check("lfCount", logQ.size(), crExp.size());
        for (int i = 0; i < crExp.size(); i++) check("lfData", {24'd0, logQ[i].data}, {24'd0, crExp[i]});
        check("lfLevel", 32'(bus.level_o), 32'd0);

        // asynchronous reset with bytes queued
        logQ.delete();
        holdBusy = 1'b1;
        for (int i = 0; i < 5; i++) pushByte(8'h30 + 8'(i));
        check("midLevel", 32'(bus.level_o), 32'd5);
        #2 rst = 1'b1;
        #1;
        check("arLevel", 32'(bus.level_o), 32'd0);
        check("arEmpty", {31'd0, bus.empty_o}, 32'd1);
        check("arFull",  {31'd0, bus.full_o}, 32'd0);
        check("arOvf",   {31'd0, bus.ovf_o}, 32'd0);
        check("arWr",    {31'd0, bus.uartWr_o}, 32'd0);
        check("arData",  {24'd0, bus.uartData_o}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        holdBusy = 1'b0;
        repeat (40) @(negedge clk);
        check("arNoStrobe", logQ.size(), 32'd0);
        check("arEmpty2", {31'd0, bus.empty_o}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
        $finish;
    end

endmodule

// File: doc/uart_tx_queue.md
# uart_tx_queue

Byte-wide transmit queue and sequencer between the processor's memory-mapped IO write path and the `txuart` serializer. CPU writes to the UART data word are pushed into a FIFO instead of driving `txuart` directly. A small FSM pops bytes and issues one `txuart` write each time the serializer is idle, so software no longer has to poll the busy bit before every character. The SOC exposes level, full and overflow status through the UART control word.

## Interface
- `DEPTH`, default 16: FIFO entries; power of two, ≥2.
- `clk_i`  in  1: system clock; all state updates on its rising edge.
- `reset_i`  in  1: asynchronous, active-high reset.
- `wr_i`  in  1: push strobe; SOC drives `IO_memWr & IO_wordAddr[IO_UART_DAT_bit]`.
- `wdata_i`  in  8: byte to push.
- `full_o`  out  1: FIFO holds `DEPTH` entries.
- `empty_o`  out  1: FIFO holds 0 entries.
- `level_o`  out  $clog2(DEPTH)+1: current entry count, 0..DEPTH.
- `ovf_o`  out  1: sticky overflow flag.
- `ovfClr_i`  in  1: clears `ovf_o`.
- `uartWr_o`  out  1: one-cycle write strobe to `txuart` `i_wr`.
- `uartData_o`  out  8: byte to `txuart` `i_data`; valid while `uartWr_o`=1.
- `uartBusy_i`  in  1: `txuart` `o_busy`.

## Operation
- **FIFO:** circular buffer with read and write pointers plus a count.
  - Push when `wr_i` and (not full, or a pop occurs in the same cycle).
  - `wr_i` while full with no pop: the byte is dropped and `ovf_o` is set.
  - `ovf_o` is cleared by `ovfClr_i`. If set and clear happen in the same cycle, set wins.
  - Pointers wrap modulo DEPTH. `level_o` = count.
- **FSM states:** IDLE, SEND, GUARD, WAIT.
  - IDLE: when `!empty_o && !uartBusy_i`, go to SEND.
  - SEND: `uartWr_o`=1 and `uartData_o`=head byte. Pop the head, except during CR insertion (see Configuration). Go to GUARD.
  - GUARD: one cycle in which `uartBusy_i` is ignored, covering the serializer's busy-assert latency. Go to WAIT.
  - WAIT: stay while `uartBusy_i`=1. When it reads 0, go to IDLE.
- **Push during SEND:** pop and push in the same cycle are both honoured. Count is unchanged; data order is preserved.
- **Reset values:**
  - FIFO emptied and pointers cleared.
  - FSM in IDLE; any pending CR flag cleared.
  - `uartWr_o`=0, `uartData_o`=0, `ovf_o`=0, `empty_o`=1, `full_o`=0, `level_o`=0.
- **Reset mid-operation:** queued bytes are discarded. A character already inside `txuart` is handled by `txuart`'s own reset.

## Timing
- `uartWr_o` and `uartData_o` are registered FSM outputs. No combinational path runs from `wr_i` or `uartBusy_i` to any output.
- **First-byte latency:** write into an empty queue in cycle N with serializer idle:
  - cycle N+1: `empty_o`=0, `level_o`=1.
  - cycle N+2: `uartWr_o`=1.
- **Back-to-back bytes:** the next `uartWr_o` comes 2 cycles after `uartBusy_i` falls (WAIT→IDLE→SEND).
- **Strobe width:** `uartWr_o` is high for exactly one cycle per character, never two consecutive cycles.
- **Status update:** `full_o`, `empty_o` and `level_o` update one cycle after the push or pop edge.

## Configuration
- `UART_TXQ_CRLF_EN` defined:
  - When the head byte is 0x0A, SEND first emits 0x0D without popping and sets a crPending flag.
  - The next SEND emits 0x0A, pops it and clears the flag.
  - `level_o` counts stored bytes only, not inserted CRs.
- `UART_TXQ_CRLF_EN` undefined: bytes are sent verbatim and no crPending logic exists.

## Structure
- **Shared package `uart_txq_pkg`:**
  - FSM state encodings (2-bit: IDLE=0, SEND=1, GUARD=2, WAIT=3).
  - Constants `ASCII_CR`=8'h0D and `ASCII_LF`=8'h0A.
  - The UART setup word (115200 baud, 8N1, divisor 24'h000364), so SOC and bench share it.
- **Sub-module `sync_fifo`:** parameterised by width 8 and DEPTH, exposing push, pop, full, empty and level. `uart_tx_queue` holds the FSM, the overflow flag and the CR logic.

## Test plan
- **Single byte:** reset, push 0x41 with busy=0 → `uartWr_o` high exactly in cycle N+2 with `uartData_o`=0x41; `empty_o`=1 afterwards.
- **Sequencing:** push 0x48, 0x69, 0x21 back-to-back; model busy high for 20 cycles per char → three strobes in order, each 2 cycles after busy falls.
- **Overflow:** hold busy=1 and push DEPTH+2 bytes →
  - `full_o`=1, `level_o`=DEPTH, `ovf_o`=1.
  - Release busy → only the first DEPTH bytes are sent.
  - `ovfClr_i` → `ovf_o`=0.
- **Push and pop in the same cycle:** push while full in the SEND cycle → accepted, `level_o` stays DEPTH, `ovf_o` stays 0.
- **Reset mid-stream:** assert `reset_i` asynchronously with 5 bytes queued → outputs take reset values immediately; no further strobes.
- **CRLF (`UART_TXQ_CRLF_EN` defined):** push 0x61, 0x0A → strobes carry 0x61, 0x0D, 0x0A. With the macro undefined → 0x61, 0x0A.
